skin_map_ctrl: RTL

- Sequences the 2048x16 down-sampled skin-map RAM (asynchronous read, synchronous write): clears it at frame start, accumulates per-cell skin-pixel counts from the 640x480 pixel stream, and shares the single read port with the display/tracking query path.
- Cell address is {cy[4:0], cx[5:0]}, with cx = pix_x[9:4] (0..39) and cy = pix_y[8:4] (0..29).
- Sits between the skin classifier output and the skin-map RAM instance.

---
 rtl/skin_map_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/skin_map_ctrl.sv
// Skin-map RAM sequencer: clears the map each frame, accumulates per-cell skin
// counts through a one-entry flush register, and shares the RAM read port with queries.
module skin_map_ctrl #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 16,
  parameter int CLEAR_DEPTH = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              pix_skin,
  input  logic              qry_valid,
  input  logic [ADDR_W-1:0] qry_addr,
  output logic              qry_rvalid,
  output logic [DATA_W-1:0] qry_data,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              busy,
  output logic              map_done
);

  localparam int CNT_W = 9;
  localparam logic [ADDR_W-1:0] CLEAR_LAST = ADDR_W'(CLEAR_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clear_ptr_q, clear_ptr_d;
  logic                acc_valid_q, acc_valid_d;
  logic [ADDR_W-1:0]   acc_addr_q, acc_addr_d;
  logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
  logic                flush_valid_q, flush_valid_d;
  logic [ADDR_W-1:0]   flush_addr_q, flush_addr_d;
  logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic                qry_rvalid_q;
  logic [DATA_W-1:0]   qry_data_q;

  logic [ADDR_W-1:0]   pix_cell;
  logic                pix_in_range;
  logic                flush_exec;
  logic                slot_free;
  logic [DATA_W:0]     flush_sum;
  logic [DATA_W-1:0]   flush_sat;

  assign pix_cell     = ADDR_W'({pix_y[8:4], pix_x[9:4]});
  assign pix_in_range = (pix_x < 10'd640) && (pix_y < 10'd480);

  // A query owns the read port, and an abort discards the pending flush.
  assign flush_exec = flush_valid_q && !qry_valid && !frame_start &&
                      ((state_q == RUN) || (state_q == DRAIN));
  assign slot_free  = !flush_valid_q || flush_exec;

  assign flush_sum = {1'b0, ram_rdata} + (DATA_W + 1)'(flush_cnt_q);
  assign flush_sat = flush_sum[DATA_W] ? {DATA_W{1'b1}} : flush_sum[DATA_W-1:0];

  assign ram_raddr  = qry_valid ? qry_addr : flush_addr_q;
  assign busy       = (state_q != IDLE);
  assign qry_rvalid = qry_rvalid_q;
  assign qry_data   = qry_data_q;

  always_comb begin
    state_d       = state_q;
    clear_ptr_d   = clear_ptr_q;
    acc_valid_d   = acc_valid_q;
    acc_addr_d    = acc_addr_q;
    acc_cnt_d     = acc_cnt_q;
    flush_valid_d = flush_valid_q;
    flush_addr_d  = flush_addr_q;
    flush_cnt_d   = flush_cnt_q;
    ram_we        = 1'b0;
    ram_waddr     = flush_addr_q;
    ram_wdata     = flush_sat;
    pix_ready     = 1'b0;
    map_done      = 1'b0;

    if (flush_exec) begin
      ram_we        = 1'b1;
      flush_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: ;
      CLEAR: begin
        ram_we      = 1'b1;
        ram_waddr   = clear_ptr_q;
        ram_wdata   = '0;
        clear_ptr_d = clear_ptr_q + 1'b1;
        if (clear_ptr_q == CLEAR_LAST) state_d = RUN;
      end
      RUN: begin
        pix_ready = !(flush_valid_q && qry_valid);
        if (frame_end) begin
          // If the flush slot is still blocked, DRAIN moves the accumulator later.
          if (acc_valid_q && slot_free) begin
            if (acc_cnt_q != '0) begin
              flush_valid_d = 1'b1;
              flush_addr_d  = acc_addr_q;
              flush_cnt_d   = acc_cnt_q;
            end
            acc_valid_d = 1'b0;
          end
          state_d = DRAIN;
        end else if (pix_valid && pix_ready && pix_in_range) begin
          if (!acc_valid_q || (pix_cell == acc_addr_q)) begin
            acc_cnt_d = acc_cnt_q + CNT_W'(pix_skin);
          end else begin
            if (acc_cnt_q != '0) begin
              flush_valid_d = 1'b1;
              flush_addr_d  = acc_addr_q;
              flush_cnt_d   = acc_cnt_q;
            end
            acc_cnt_d = CNT_W'(pix_skin);
          end
          acc_addr_d  = pix_cell;
          acc_valid_d = 1'b1;
        end
      end
      DRAIN: begin
        if (acc_valid_q && slot_free) begin
          if (acc_cnt_q != '0) begin
            flush_valid_d = 1'b1;
            flush_addr_d  = acc_addr_q;
            flush_cnt_d   = acc_cnt_q;
          end
          acc_valid_d = 1'b0;
        end
        if (!flush_valid_q && !acc_valid_q) begin
          map_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (frame_start) begin
      state_d       = CLEAR;
      clear_ptr_d   = '0;
      acc_valid_d   = 1'b0;
      flush_valid_d = 1'b0;
      map_done      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      clear_ptr_q   <= '0;
      acc_valid_q   <= 1'b0;
      acc_addr_q    <= '0;
      acc_cnt_q     <= '0;
      flush_valid_q <= 1'b0;
      flush_addr_q  <= '0;
      flush_cnt_q   <= '0;
      qry_rvalid_q  <= 1'b0;
      qry_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      clear_ptr_q   <= clear_ptr_d;
      acc_valid_q   <= acc_valid_d;
      acc_addr_q    <= acc_addr_d;
      acc_cnt_q     <= acc_cnt_d;
      flush_valid_q <= flush_valid_d;
      flush_addr_q  <= flush_addr_d;
      flush_cnt_q   <= flush_cnt_d;
      qry_rvalid_q  <= qry_valid;
      if (qry_valid) qry_data_q <= ram_rdata;
    end
  end

endmodule
